// File: rtl/missle_collision_pkg.sv
// Shared game constants and the missile-collision FSM state encoding.
// Imported by the collision top level and by other sprite-collision blocks.
package missle_collision_pkg;

  localparam int unsigned SCREEN_W = 1024;
  localparam int unsigned SCREEN_H = 768;
  localparam int unsigned COORD_W  = 12;

  localparam int unsigned ENEMY_W  = 48;
  localparam int unsigned ENEMY_H  = 32;
  localparam int unsigned MISSLE_W = 4;
  localparam int unsigned MISSLE_H = 16;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StScan = 2'b01,
    StHit  = 2'b10,
    StLock = 2'b11
  } state_e;

endpackage

// File: rtl/missle_collision_rect_overlap.sv
// Combinational axis-aligned rectangle overlap test.
// Rectangles are given by top-left corner and fixed size. Coordinates are widened by one bit
// before adding the size so the right/bottom edge never wraps. Touching edges do not overlap.
// Ports:
//   a_x_i, a_y_i  top-left of rectangle A (size AW x AH)
//   b_x_i, b_y_i  top-left of rectangle B (size BW x BH)
//   overlap_o     high when the interiors intersect
module missle_collision_rect_overlap #(
  parameter int unsigned CW = 12,
  parameter int unsigned AW = 4,
  parameter int unsigned AH = 16,
  parameter int unsigned BW = 48,
  parameter int unsigned BH = 32
) (
  input  logic [CW-1:0] a_x_i,
  input  logic [CW-1:0] a_y_i,
  input  logic [CW-1:0] b_x_i,
  input  logic [CW-1:0] b_y_i,
  output logic          overlap_o
);

  logic [CW:0] a_l, a_t, a_r, a_b;
  logic [CW:0] b_l, b_t, b_r, b_b;

  always_comb begin
    a_l = {1'b0, a_x_i};
    a_t = {1'b0, a_y_i};
    b_l = {1'b0, b_x_i};
    b_t = {1'b0, b_y_i};
    a_r = a_l + (CW + 1)'(AW);
    a_b = a_t + (CW + 1)'(AH);
    b_r = b_l + (CW + 1)'(BW);
    b_b = b_t + (CW + 1)'(BH);
    overlap_o = (a_l < b_r) && (b_l < a_r) && (a_t < b_b) && (b_t < a_b);
  end

endmodule

// File: rtl/missle_collision.sv
// Player-missile vs enemy collision checker.
// Once per frame (frame_tick while the missile flies) the latched missile rectangle is tested
// against one enemy slot per cycle, lowest index first. The first alive, overlapping enemy gets a
// one-cycle kill pulse together with missle_hit, and the score grows by POINTS (saturating).
// After a kill the block waits for the missile to disappear so one missile kills at most once.
// Ports:
//   pclk, rst       pixel clock, synchronous active-high reset
//   frame_tick      start-of-vblank pulse that launches a scan
//   missle_on       missile in flight; dropping it aborts a scan / releases the lock
//   missle_xpos/ypos missile top-left, latched at scan start
//   enemy_alive     per-slot alive flags
//   enemy_xpos/ypos packed enemy top-left coordinates, slot i at [12*i +: 12], sampled live
//   score_clr       clears the score, wins over a same-cycle increment
//   enemy_kill      one-hot kill pulse
//   missle_hit      pulse coincident with enemy_kill
//   score           accumulated score
//   busy            high while scanning or in the hit cycle
module missle_collision
  import missle_collision_pkg::*;
#(
  parameter int unsigned N_ENEMY  = 8,
  parameter int unsigned ENEMY_W  = missle_collision_pkg::ENEMY_W,
  parameter int unsigned ENEMY_H  = missle_collision_pkg::ENEMY_H,
  parameter int unsigned MISSLE_W = missle_collision_pkg::MISSLE_W,
  parameter int unsigned MISSLE_H = missle_collision_pkg::MISSLE_H,
  parameter int unsigned SCORE_W  = 16,
  parameter int unsigned POINTS   = 10
) (
  input  logic                   pclk,
  input  logic                   rst,
  input  logic                   frame_tick,
  input  logic                   missle_on,
  input  logic [11:0]            missle_xpos,
  input  logic [11:0]            missle_ypos,
  input  logic [N_ENEMY-1:0]     enemy_alive,
  input  logic [12*N_ENEMY-1:0]  enemy_xpos,
  input  logic [12*N_ENEMY-1:0]  enemy_ypos,
  input  logic                   score_clr,
  output logic [N_ENEMY-1:0]     enemy_kill,
  output logic                   missle_hit,
  output logic [SCORE_W-1:0]     score,
  output logic                   busy
);

  localparam int unsigned IdxW = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_ENEMY - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [11:0]         mx_q, mx_d;
  logic [11:0]         my_q, my_d;
  logic [N_ENEMY-1:0]  kill_q, kill_d;
  logic                hit_q, hit_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                busy_q, busy_d;

  logic [11:0]         ex, ey;
  logic                overlap;
  logic                slot_hit;
  logic [SCORE_W:0]    score_sum;

  // Current slot's coordinates; idx_q doubles as the latched hit index in StHit.
  assign ex = enemy_xpos[12*idx_q +: 12];
  assign ey = enemy_ypos[12*idx_q +: 12];

  missle_collision_rect_overlap #(
    .CW (12),
    .AW (MISSLE_W),
    .AH (MISSLE_H),
    .BW (ENEMY_W),
    .BH (ENEMY_H)
  ) u_overlap (
    .a_x_i     (mx_q),
    .a_y_i     (my_q),
    .b_x_i     (ex),
    .b_y_i     (ey),
    .overlap_o (overlap)
  );

  assign slot_hit  = enemy_alive[idx_q] & overlap;
  assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(POINTS);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mx_d    = mx_q;
    my_d    = my_q;
    kill_d  = '0;
    hit_d   = 1'b0;
    score_d = score_q;

    unique case (state_q)
      StIdle: begin
        if (frame_tick && missle_on) begin
          mx_d    = missle_xpos;
          my_d    = missle_ypos;
          idx_d   = '0;
          state_d = StScan;
        end
      end
      StScan: begin
        // Abort has priority over a hit detected in the same cycle.
        if (!missle_on) begin
          state_d = StIdle;
        end else if (slot_hit) begin
          state_d = StHit;
        end else if (idx_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StHit: begin
        kill_d[idx_q] = 1'b1;
        hit_d         = 1'b1;
        score_d       = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        state_d       = StLock;
      end
      StLock: begin
        if (!missle_on) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (score_clr) begin
      score_d = '0;
    end

    busy_d = (state_d == StScan) || (state_d == StHit);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      kill_q  <= '0;
      hit_q   <= 1'b0;
      score_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      kill_q  <= kill_d;
      hit_q   <= hit_d;
      score_q <= score_d;
      busy_q  <= busy_d;
    end
  end

  assign enemy_kill = kill_q;
  assign missle_hit = hit_q;
  assign score      = score_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_missle_collision.sv
module tb_missle_collision;

  logic        pclk = 1'b0;
  logic        rst;
  logic        frame_tick;
  logic        missle_on;
  logic [11:0] missle_xpos;
  logic [11:0] missle_ypos;
  logic [7:0]  enemy_alive;
  logic [95:0] enemy_xpos;
  logic [95:0] enemy_ypos;
  logic        score_clr;
  logic [7:0]  enemy_kill;
  logic        missle_hit;
  logic [15:0] score;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  missle_collision u_dut (
    .pclk        (pclk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .missle_on   (missle_on),
    .missle_xpos (missle_xpos),
    .missle_ypos (missle_ypos),
    .enemy_alive (enemy_alive),
    .enemy_xpos  (enemy_xpos),
    .enemy_ypos  (enemy_ypos),
    .score_clr   (score_clr),
    .enemy_kill  (enemy_kill),
    .missle_hit  (missle_hit),
    .score       (score),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_enemy(input int i, input int x, input int y, input logic alive);
    enemy_xpos[12*i +: 12] = 12'(x);
    enemy_ypos[12*i +: 12] = 12'(y);
    enemy_alive[i]         = alive;
  endtask

  // All slots parked far from the missile and dead.
  task automatic clear_enemies();
    for (int i = 0; i < 8; i++) set_enemy(i, 800, 600, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst = 1'b1; frame_tick = 1'b0; missle_on = 1'b0; score_clr = 1'b0;
    @(negedge pclk);
    rst = 1'b0;
  endtask

  // Drop the missile for one cycle so a locked FSM returns to idle.
  task automatic release_missile();
    @(negedge pclk);
    missle_on = 1'b0;
    @(negedge pclk);
  endtask

  // Launch one frame and watch the outputs for a bounded number of cycles.
  task automatic run_frame(input int cycles, output int pulses, output logic [7:0] kill_or,
                           output int busy_cyc, output int hit_at, output int incoh);
    pulses = 0; kill_or = '0; busy_cyc = 0; hit_at = -1; incoh = 0;
    @(negedge pclk);
    frame_tick = 1'b1; missle_on = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge pclk);
      frame_tick = 1'b0;
      if (missle_hit) begin
        pulses++;
        if (hit_at < 0) hit_at = c;
      end
      kill_or |= enemy_kill;
      if (busy) busy_cyc++;
      if (missle_hit !== (enemy_kill != 8'h00)) incoh++;
    end
  endtask

  int          pulses, busy_cyc, hit_at, incoh, acc;
  logic [7:0]  kill_or;

  typedef struct {int x; int y; logic hit;} vec_t;
  vec_t edge_vecs[8];

  initial begin
    rst = 1'b1; frame_tick = 1'b0; missle_on = 1'b0; score_clr = 1'b0;
    missle_xpos = 12'd120; missle_ypos = 12'd220;
    enemy_alive = '0; enemy_xpos = '0; enemy_ypos = '0;
    clear_enemies();

    // Reset values
    do_reset();
    check("rst_kill", 32'(enemy_kill), 32'h0);
    check("rst_hit", 32'(missle_hit), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // 1: single hit on enemy 0
    set_enemy(0, 100, 200, 1'b1);
    run_frame(12, pulses, kill_or, busy_cyc, hit_at, incoh);
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_kill", 32'(kill_or), 32'h01);
    check("t1_latency", 32'(hit_at), 32'd2);
    check("t1_coincident", 32'(incoh), 32'd0);
    check("t1_score", 32'(score), 32'd10);
    release_missile();

    // 2: lowest index wins, then lock holds over further frames
    do_reset();
    clear_enemies();
    set_enemy(2, 110, 210, 1'b1);
    set_enemy(5, 110, 210, 1'b1);
    run_frame(12, pulses, kill_or, busy_cyc, hit_at, incoh);
    check("t2_kill", 32'(kill_or), 32'h04);
    check("t2_pulses", 32'(pulses), 32'd1);
    acc = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame(12, pulses, kill_or, busy_cyc, hit_at, incoh);
      acc += pulses;
    end
    check("t2_locked_pulses", 32'(acc), 32'd0);
    check("t2_score", 32'(score), 32'd10);
    release_missile();

    // 3: edge touching vs. one-pixel overlap on all four sides
    clear_enemies();
    set_enemy(0, 100, 200, 1'b1);
    edge_vecs = '{'{148, 220, 1'b0}, '{147, 220, 1'b1}, '{96, 220, 1'b0}, '{97, 220, 1'b1},
                  '{120, 232, 1'b0}, '{120, 231, 1'b1}, '{120, 184, 1'b0}, '{120, 185, 1'b1}};
    for (int v = 0; v < 8; v++) begin
      missle_xpos = 12'(edge_vecs[v].x);
      missle_ypos = 12'(edge_vecs[v].y);
      run_frame(12, pulses, kill_or, busy_cyc, hit_at, incoh);
      check($sformatf("t3_edge_%0d_%0d", edge_vecs[v].x, edge_vecs[v].y), 32'(pulses),
            32'(edge_vecs[v].hit));
      release_missile();
    end
    missle_xpos = 12'd120; missle_ypos = 12'd220;

    // 4: missile drops at idx 3 while enemy 6 would be hit
    do_reset();
    clear_enemies();
    set_enemy(6, 110, 210, 1'b1);
    @(negedge pclk); frame_tick = 1'b1; missle_on = 1'b1;
    @(negedge pclk); frame_tick = 1'b0;
    repeat (3) @(negedge pclk);
    check("t4_busy_at_idx3", 32'(busy), 32'd1);
    missle_on = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge pclk);
      if (missle_hit || enemy_kill != 0) acc++;
    end
    check("t4_abort_pulses", 32'(acc), 32'd0);
    check("t4_abort_busy", 32'(busy), 32'd0);
    check("t4_abort_score", 32'(score), 32'd0);
    // abort in the same cycle as a hit on slot 0
    clear_enemies();
    set_enemy(0, 100, 200, 1'b1);
    @(negedge pclk); frame_tick = 1'b1; missle_on = 1'b1;
    @(negedge pclk); frame_tick = 1'b0; missle_on = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge pclk);
      if (missle_hit || enemy_kill != 0) acc++;
    end
    check("t4_abort_same_cycle", 32'(acc), 32'd0);

    // 5: saturation, then score_clr overriding the HIT increment
    do_reset();
    for (int k = 0; k < 6553; k++) begin
      run_frame(4, pulses, kill_or, busy_cyc, hit_at, incoh);
      release_missile();
    end
    check("t5_preload", 32'(score), 32'hFFFA);
    run_frame(4, pulses, kill_or, busy_cyc, hit_at, incoh);
    release_missile();
    check("t5_saturate", 32'(score), 32'hFFFF);
    run_frame(4, pulses, kill_or, busy_cyc, hit_at, incoh);
    release_missile();
    check("t5_saturate_hold", 32'(score), 32'hFFFF);
    @(negedge pclk); frame_tick = 1'b1; missle_on = 1'b1;
    @(negedge pclk); frame_tick = 1'b0;
    @(negedge pclk); score_clr = 1'b1;
    @(negedge pclk); score_clr = 1'b0;
    check("t5_clr_kill", 32'(enemy_kill), 32'h01);
    check("t5_clr_score", 32'(score), 32'h0);
    release_missile();

    // 6: reset mid-scan and in HIT; frame_tick during SCAN ignored
    do_reset();
    run_frame(4, pulses, kill_or, busy_cyc, hit_at, incoh);
    release_missile();
    check("t6_pre_score", 32'(score), 32'd10);
    enemy_alive = '0;
    @(negedge pclk); frame_tick = 1'b1; missle_on = 1'b1;
    @(negedge pclk); frame_tick = 1'b0;
    @(negedge pclk); rst = 1'b1;
    @(negedge pclk); rst = 1'b0;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_kill", 32'(enemy_kill), 32'h0);
    check("t6_rst_score", 32'(score), 32'd0);
    set_enemy(0, 100, 200, 1'b1);
    missle_on = 1'b0;
    @(negedge pclk); frame_tick = 1'b1; missle_on = 1'b1;
    @(negedge pclk); frame_tick = 1'b0;
    @(negedge pclk); rst = 1'b1;
    @(negedge pclk); rst = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      if (missle_hit || enemy_kill != 0) acc++;
      @(negedge pclk);
    end
    check("t6_rst_hit_pulses", 32'(acc), 32'd0);
    check("t6_rst_hit_score", 32'(score), 32'd0);
    enemy_alive = '0;
    missle_on = 1'b0;
    @(negedge pclk); frame_tick = 1'b1; missle_on = 1'b1;
    busy_cyc = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge pclk);
      frame_tick = (c == 2);
      if (busy) busy_cyc++;
    end
    frame_tick = 1'b0;
    check("t6_scan_len", 32'(busy_cyc), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
